// File: rtl/atri_i2c_cmd_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : atri_i2c_cmd_loader_pkg
// Brief    : Shared encodings for the I2C command loader: FSM states,
//            status codes and command frame header offsets.
// Revision : 1.0 - initial release
// ============================================================================
package atri_i2c_cmd_loader_pkg;

    localparam int c_state_w = 4;

    localparam logic [c_state_w-1:0] c_s_h0      = 4'd0;
    localparam logic [c_state_w-1:0] c_s_h1      = 4'd1;
    localparam logic [c_state_w-1:0] c_s_h2      = 4'd2;
    localparam logic [c_state_w-1:0] c_s_write   = 4'd3;
    localparam logic [c_state_w-1:0] c_s_jump    = 4'd4;
    localparam logic [c_state_w-1:0] c_s_wait    = 4'd5;
    localparam logic [c_state_w-1:0] c_s_drain   = 4'd6;
    localparam logic [c_state_w-1:0] c_s_status  = 4'd7;
    localparam logic [c_state_w-1:0] c_s_rd_addr = 4'd8;
    localparam logic [c_state_w-1:0] c_s_rd_wait = 4'd9;
    localparam logic [c_state_w-1:0] c_s_rd_out  = 4'd10;

    localparam logic [7:0] ST_OK      = 8'h00;
    localparam logic [7:0] ST_TIMEOUT = 8'h01;
    localparam logic [7:0] ST_LENERR  = 8'h02;

    // Byte positions of the frame header; payload follows at c_hdr_len.
    localparam int c_hdr_target = 0;
    localparam int c_hdr_wr_len = 1;
    localparam int c_hdr_rd_len = 2;
    localparam int c_hdr_len    = 3;

endpackage
`default_nettype wire

// File: rtl/atri_i2c_cmd_loader.sv
`default_nettype none
// ============================================================================
// Module   : atri_i2c_cmd_loader
// Brief    : Host command front end for the PicoBlaze I2C controller. Loads
//            the payload into the RAM window, patches the jump slot, waits for
//            completion and streams back status plus result bytes.
// Revision : 1.0 - initial release
// ============================================================================
module atri_i2c_cmd_loader
    import atri_i2c_cmd_loader_pkg::*;
#(
    parameter logic [7:0] CMD_BASE = 8'h00,
    parameter logic [7:0] RSP_BASE = 8'h80,
    parameter int         MAX_LEN  = 64,
    parameter int         TIMEOUT  = 1000000,
    parameter int         TO_W     = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] ram_address,
    output logic [7:0] ram_data_in,
    output logic       ram_wr_stb,
    output logic       jump_wr_stb,
    input  logic [7:0] ram_data_out,
    input  logic       pb_done,
    output logic       busy
);

    localparam logic [7:0]      c_max_len = 8'(MAX_LEN);
    localparam logic [TO_W-1:0] c_to_last = TO_W'(TIMEOUT - 1);

    logic [c_state_w-1:0] r_state, w_state_nxt;
    logic [7:0]           r_target, w_target_nxt;
    logic [7:0]           r_wr_len, w_wr_len_nxt;
    logic [7:0]           r_rd_len, w_rd_len_nxt;
    logic [6:0]           r_idx, w_idx_nxt;
    logic [7:0]           r_err, w_err_nxt;
    logic [TO_W-1:0]      r_cnt, w_cnt_nxt;

    logic       r_cmd_ready, w_cmd_ready_nxt;
    logic [7:0] r_rsp_data, w_rsp_data_nxt;
    logic       r_rsp_valid, w_rsp_valid_nxt;
    logic [7:0] r_ram_address, w_ram_address_nxt;
    logic [7:0] r_ram_data_in, w_ram_data_in_nxt;
    logic       r_ram_wr_stb, w_ram_wr_stb_nxt;
    logic       r_jump_wr_stb, w_jump_wr_stb_nxt;
    logic       r_busy, w_busy_nxt;

    logic w_cmd_acc;
    logic w_rsp_acc;

    assign w_cmd_acc = cmd_valid & r_cmd_ready;
    assign w_rsp_acc = r_rsp_valid & rsp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_s_h0;
            r_target      <= '0;
            r_wr_len      <= '0;
            r_rd_len      <= '0;
            r_idx         <= '0;
            r_err         <= '0;
            r_cnt         <= '0;
            r_cmd_ready   <= 1'b1;
            r_rsp_data    <= '0;
            r_rsp_valid   <= 1'b0;
            r_ram_address <= '0;
            r_ram_data_in <= '0;
            r_ram_wr_stb  <= 1'b0;
            r_jump_wr_stb <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_target      <= w_target_nxt;
            r_wr_len      <= w_wr_len_nxt;
            r_rd_len      <= w_rd_len_nxt;
            r_idx         <= w_idx_nxt;
            r_err         <= w_err_nxt;
            r_cnt         <= w_cnt_nxt;
            r_cmd_ready   <= w_cmd_ready_nxt;
            r_rsp_data    <= w_rsp_data_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_ram_address <= w_ram_address_nxt;
            r_ram_data_in <= w_ram_data_in_nxt;
            r_ram_wr_stb  <= w_ram_wr_stb_nxt;
            r_jump_wr_stb <= w_jump_wr_stb_nxt;
            r_busy        <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_target_nxt      = r_target;
        w_wr_len_nxt      = r_wr_len;
        w_rd_len_nxt      = r_rd_len;
        w_idx_nxt         = r_idx;
        w_err_nxt         = r_err;
        w_cnt_nxt         = '0;
        w_rsp_data_nxt    = r_rsp_data;
        w_ram_address_nxt = r_ram_address;
        w_ram_data_in_nxt = r_ram_data_in;
        w_ram_wr_stb_nxt  = 1'b0;

        case (r_state)
            c_s_h0: begin
                if (w_cmd_acc) begin
                    w_target_nxt = cmd_data;
                    w_state_nxt  = c_s_h1;
                end
            end
            c_s_h1: begin
                if (w_cmd_acc) begin
                    w_wr_len_nxt = cmd_data;
                    w_state_nxt  = c_s_h2;
                end
            end
            c_s_h2: begin
                if (w_cmd_acc) begin
                    w_rd_len_nxt = cmd_data;
                    w_idx_nxt    = '0;
                    if ((r_wr_len > c_max_len) || (cmd_data > c_max_len)) begin
                        w_err_nxt   = ST_LENERR;
                        w_state_nxt = (r_wr_len == 8'd0) ? c_s_status : c_s_drain;
                    end else begin
                        w_state_nxt = (r_wr_len == 8'd0) ? c_s_jump : c_s_write;
                    end
                end
            end
            c_s_write: begin
                // The strobe cycle doubles as the byte-count decision point.
                if (r_ram_wr_stb) begin
                    if ({1'b0, r_idx} == r_wr_len - 8'd1) begin
                        w_state_nxt = c_s_jump;
                    end else begin
                        w_idx_nxt = r_idx + 7'd1;
                    end
                end else if (w_cmd_acc) begin
                    w_ram_address_nxt = CMD_BASE + {1'b0, r_idx};
                    w_ram_data_in_nxt = cmd_data;
                    w_ram_wr_stb_nxt  = 1'b1;
                end
            end
            c_s_jump: begin
                w_cnt_nxt   = r_cnt + 1'b1;
                w_state_nxt = c_s_wait;
            end
            c_s_wait: begin
                // Counter runs from the jump cycle, so expiry lands the
                // status byte TIMEOUT cycles after the jump strobe.
                if (pb_done) begin
                    w_err_nxt   = ST_OK;
                    w_state_nxt = c_s_status;
                end else if (r_cnt >= c_to_last) begin
                    w_err_nxt   = ST_TIMEOUT;
                    w_state_nxt = c_s_status;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            c_s_drain: begin
                // wr_len can exceed the 7-bit index here, so count it down.
                if (w_cmd_acc) begin
                    if (r_wr_len == 8'd1) begin
                        w_state_nxt = c_s_status;
                    end else begin
                        w_wr_len_nxt = r_wr_len - 8'd1;
                    end
                end
            end
            c_s_status: begin
                if (w_rsp_acc) begin
                    if ((r_err == ST_OK) && (r_rd_len != 8'd0)) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = c_s_rd_addr;
                    end else begin
                        w_state_nxt = c_s_h0;
                    end
                end
            end
            c_s_rd_addr: begin
                w_state_nxt = c_s_rd_wait;
            end
            c_s_rd_wait: begin
                w_rsp_data_nxt = ram_data_out;
                w_state_nxt    = c_s_rd_out;
            end
            c_s_rd_out: begin
                if (w_rsp_acc) begin
                    if ({1'b0, r_idx} == r_rd_len - 8'd1) begin
                        w_state_nxt = c_s_h0;
                    end else begin
                        w_idx_nxt   = r_idx + 7'd1;
                        w_state_nxt = c_s_rd_addr;
                    end
                end
            end
            default: begin
                w_state_nxt = c_s_h0;
            end
        endcase

        // Registered outputs follow the state being entered.
        if (w_state_nxt == c_s_status) begin
            w_rsp_data_nxt = w_err_nxt;
        end
        if (w_state_nxt == c_s_rd_addr) begin
            w_ram_address_nxt = RSP_BASE + {1'b0, w_idx_nxt};
        end
        if (w_state_nxt == c_s_jump) begin
            w_ram_data_in_nxt = w_target_nxt;
        end

        w_cmd_ready_nxt   = (w_state_nxt == c_s_h0) || (w_state_nxt == c_s_h1) ||
                            (w_state_nxt == c_s_h2) || (w_state_nxt == c_s_drain) ||
                            ((w_state_nxt == c_s_write) && !w_ram_wr_stb_nxt);
        w_rsp_valid_nxt   = (w_state_nxt == c_s_status) || (w_state_nxt == c_s_rd_out);
        w_jump_wr_stb_nxt = (w_state_nxt == c_s_jump);
        w_busy_nxt        = (w_state_nxt != c_s_h0);
    end

    assign cmd_ready   = r_cmd_ready;
    assign rsp_data    = r_rsp_data;
    assign rsp_valid   = r_rsp_valid;
    assign ram_address = r_ram_address;
    assign ram_data_in = r_ram_data_in;
    assign ram_wr_stb  = r_ram_wr_stb;
    assign jump_wr_stb = r_jump_wr_stb;
    assign busy        = r_busy;

endmodule
`default_nettype wire
